bcd_seq_adder_ctrl: RTL and testbench
=====================================

Name: bcd_seq_adder_ctrl

Overview:
- Sequencer for multi-digit BCD addition that time-shares one external single-digit BCD adder. That adder takes A, B, cin and returns S1 (carry digit) and S0 (sum digit).
- Latches two DIGITS-wide packed BCD operands on a start request and feeds the shared adder one digit per clock, least significant digit first.
- Chains the decimal carry between digits, assembles the packed result and signals completion with a one-cycle done pulse.
- Sits between the operand source (keypad/register logic) and the 7-segment display path.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal range 1..8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
b  input  4*DIGITS  operand B, packed BCD
cin  input  1  initial carry into digit 0
dig_a  output  4  digit of A driven to shared adder
dig_b  output  4  digit of B driven to shared adder
dig_cin  output  1  carry driven to shared adder
dig_s0  input  4  adder sum digit (0..9), combinational from dig_a/dig_b/dig_cin
dig_s1  input  4  adder carry digit (0 or 1); only bit 0 used
sum  output  4*DIGITS  packed BCD result
cout  output  1  decimal carry out of top digit
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
err  output  1  operand contained a non-BCD digit (>9)

Behaviour:
- Reset: when rst_n=0 at a rising edge, the following apply regardless of state, including mid-operation.
  - State goes to IDLE.
  - sum, cout, busy, done, err, dig_a, dig_b, dig_cin, the internal digit index and the carry register all go to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - dig_a, dig_b and dig_cin are 0. sum, cout and err hold their last values.
  - On start=1: latch a, b and cin into internal registers; index := 0; carry := cin; clear sum, cout and err.
  - Next state on start: if any digit of a or b is >9, go to DONE with err=1 (sum=0, cout=0). Otherwise go to RUN.
- RUN:
  - dig_a = a_reg digit[index], dig_b = b_reg digit[index], dig_cin = carry. All three come from registers, so they are stable for the whole cycle.
  - At each clock edge: sum digit[index] := dig_s0; carry := dig_s1[0]; index := index+1.
  - When index = DIGITS-1 at the edge: cout := dig_s1[0] and next state is DONE.
  - RUN lasts exactly DIGITS cycles.
- DONE:
  - done=1 for exactly one cycle; the next state is IDLE unconditionally.
  - dig_* outputs are 0.
- Latency: the start edge is cycle 0, so done is high during cycle DIGITS+1 (cycle 1 for the err path).
- Output stability: sum, cout and err are stable from the done cycle until the next accepted start. Intermediate sum digits may be observed during RUN but are not guaranteed.
- Back-to-back operation: start asserted in RUN or DONE is ignored and not queued. The earliest accepted restart is the cycle after done.
- busy = (state != IDLE), registered.
- Widths: index is ceil(log2(DIGITS)) bits, minimum 1. For DIGITS=1, RUN lasts one cycle.
- Adder outputs: the block does not range-check dig_s0. A dig_s1 value other than 0 or 1 is a shared-adder fault and is outside this block's scope.
- Operands: a, b and cin are sampled only at the accepting edge; changes afterwards have no effect.

Test Plan:
- DIGITS=4, a=0x1234, b=0x5678, cin=0, start pulse -> dig_a sequence 4,3,2,1; done in cycle 5; sum=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, cin=0 -> dig_cin sequence 0,1,1,1; sum=0x0000, cout=1.
- a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0; a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
- a=0x00A0, b=0x0001 -> no RUN cycles; done in cycle 1; err=1, sum=0, cout=0, busy high for one cycle.
- start held high continuously with a=0x0005, b=0x0005 -> first result sum=0x0010. The next operation is accepted only in the cycle after done. Changing a during RUN does not alter the result.
- rst_n=0 in the 2nd RUN cycle -> next cycle state IDLE, all outputs 0, no done pulse. A fresh start afterwards completes correctly (0x1234+0x5678 -> 0x6912).

Source files
------------

// File: rtl/bcd_seq_adder_ctrl.sv
// bcd_seq_adder_ctrl
// Sequences a multi-digit packed BCD addition through one shared external
// single-digit BCD adder, one digit per clock, least significant digit first.
//
// Ports:
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   start             operation request, sampled only in IDLE
//   a, b, cin         packed BCD operands (digit 0 in [3:0]) and carry-in
//   dig_a/dig_b/dig_cin  digit operands and carry driven to the shared adder
//   dig_s0, dig_s1    shared adder sum digit and carry digit (bit 0 used)
//   sum, cout         packed BCD result and decimal carry out
//   busy              high while RUN or DONE
//   done              one-cycle completion pulse
//   err               an operand held a non-BCD digit
module bcd_seq_adder_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic [3:0]          dig_a,
  output logic [3:0]          dig_b,
  output logic                dig_cin,
  input  logic [3:0]          dig_s0,
  input  logic [3:0]          dig_s1,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [DIGITS-1:0][3:0] digits_t;

  state_t  state_q, state_d;
  digits_t a_q, a_d, b_q, b_d, sum_q, sum_d;
  digits_t a_in, b_in;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [3:0] dig_a_q, dig_a_d, dig_b_q, dig_b_d;
  logic dig_cin_q, dig_cin_d;

  // Upper carry-digit bits are outside this block's scope.
  logic unused_s1;
  assign unused_s1 = ^dig_s1[3:1];

  assign a_in = a;
  assign b_in = b;

  // True when any digit of the operand exceeds 9.
  function automatic logic has_bad_digit(input digits_t v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[i] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    err_d     = err_q;
    done_d    = 1'b0;
    dig_a_d   = 4'd0;
    dig_b_d   = 4'd0;
    dig_cin_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          idx_d   = '0;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
          if (has_bad_digit(a_in) || has_bad_digit(b_in)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Present digit 0 in the first RUN cycle straight from registers.
            dig_a_d   = a_in[0];
            dig_b_d   = b_in[0];
            dig_cin_d = cin;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        sum_d[idx_q] = dig_s0;
        carry_d      = dig_s1[0];
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = dig_s1[0];
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d     = idx_q + 1'b1;
          dig_a_d   = a_q[idx_q + 1'b1];
          dig_b_d   = b_q[idx_q + 1'b1];
          dig_cin_d = dig_s1[0];
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dig_a_q   <= 4'd0;
      dig_b_q   <= 4'd0;
      dig_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      dig_a_q   <= dig_a_d;
      dig_b_q   <= dig_b_d;
      dig_cin_q <= dig_cin_d;
    end
  end

  assign sum     = sum_q;
  assign cout    = cout_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign dig_a   = dig_a_q;
  assign dig_b   = dig_b_q;
  assign dig_cin = dig_cin_q;

endmodule

// File: tb/tb_bcd_seq_adder_ctrl.sv
// Bench for bcd_seq_adder_ctrl (DIGITS=4) with a behavioural shared BCD adder
// and a done-triggered scoreboard for {sum, cout, err}.
module tb_bcd_seq_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic [3:0]  dig_a, dig_b;
  logic        dig_cin;
  logic [3:0]  dig_s0, dig_s1;
  logic [15:0] sum;
  logic        cout, busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [17:0] sb_q[$];

  bcd_seq_adder_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .dig_a(dig_a), .dig_b(dig_b), .dig_cin(dig_cin),
    .dig_s0(dig_s0), .dig_s1(dig_s1),
    .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Shared single-digit BCD adder.
  logic [4:0] raw;
  always_comb begin
    raw = 5'(dig_a) + 5'(dig_b) + 5'(dig_cin);
    if (raw > 5'd9) begin
      dig_s1 = 4'd1;
      dig_s0 = 4'(raw - 5'd10);
    end else begin
      dig_s1 = 4'd0;
      dig_s0 = raw[3:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        logic [17:0] e;
        e = sb_q.pop_front();
        check("result_sum_cout_err", 32'({sum, cout, err}), 32'(e));
      end
    end
  end

  // One operation; returns done cycle and the observed dig_a/dig_cin sequences.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                        input logic [15:0] es, input logic ec, input logic ee,
                        output int lat, output logic [15:0] seq_a, output logic [3:0] seq_c);
    int cyc;
    seq_a = '0;
    seq_c = '0;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    sb_q.push_back({es, ec, ee});
    @(negedge clk);
    start = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      seq_a = {seq_a[11:0], dig_a};
      seq_c = {seq_c[2:0], dig_cin};
      @(negedge clk);
      cyc++;
    end
    lat = (done === 1'b1) ? cyc : -1;
    check("busy_in_done_cycle", 32'(busy), 32'(1));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'(0));
    check("busy_after_done", 32'(busy), 32'(0));
  endtask

  int lat;
  logic [15:0] sa;
  logic [3:0] sc;
  int d1, d2;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_flags", 32'({cout, busy, done, err}), 32'(0));
    check("rst_dig", 32'({dig_a, dig_b, dig_cin}), 32'(0));
    rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, lat, sa, sc);
    check("lat_1234", 32'(lat), 32'(5));
    check("seq_dig_a_1234", 32'(sa), 32'h4321);
    repeat (3) @(negedge clk);
    check("idle_holds_sum", 32'(sum), 32'h6912);
    check("idle_dig_zero", 32'({dig_a, dig_b, dig_cin}), 32'(0));

    run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, lat, sa, sc);
    check("seq_dig_cin_9999", 32'(sc), 32'b0111);
    check("lat_9999", 32'(lat), 32'(5));

    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, lat, sa, sc);
    check("seq_dig_cin_cin1", 32'(sc), 32'b1000);
    run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, lat, sa, sc);
    check("lat_9999x2", 32'(lat), 32'(5));

    run_op(16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, lat, sa, sc);
    check("lat_err", 32'(lat), 32'(1));

    // Start held high; a changes mid-RUN and is picked up only by the restart.
    @(negedge clk);
    a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
    sb_q.push_back({16'h0010, 1'b0, 1'b0});
    sb_q.push_back({16'h0012, 1'b0, 1'b0});
    d1 = -1; d2 = -1;
    for (int k = 1; k < 40 && d2 < 0; k++) begin
      @(negedge clk);
      if (k == 2) a = 16'h0007;
      if (k == 6) check("held_start_idle_busy", 32'(busy), 32'(0));
      if (k == 7) begin
        check("held_start_accepted", 32'(busy), 32'(1));
        start = 1'b0;
      end
      if (done === 1'b1) begin
        if (d1 < 0) d1 = k; else d2 = k;
      end
    end
    check("held_first_done", 32'(d1), 32'(5));
    check("held_second_done", 32'(d2), 32'(11));
    repeat (2) @(negedge clk);

    // Reset during the second RUN cycle aborts with no done pulse.
    d1 = n_done;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_rst_sum", 32'(sum), 32'(0));
    check("midrun_rst_flags", 32'({cout, busy, done, err}), 32'(0));
    check("midrun_rst_dig", 32'({dig_a, dig_b, dig_cin}), 32'(0));
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrun_no_done", 32'(n_done), 32'(d1));

    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, lat, sa, sc);
    check("post_rst_lat", 32'(lat), 32'(5));

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
